floating_point_divider_seq: RTL and testbench
=============================================

// Module: floating_point_divider_seq
// PURPOSE
//  Sequential IEEE-754 single-precision divider, Quotient = A / B; the inverse operation to the ALU's combinational FP multiplier.
//  Restoring shift-subtract on 24-bit significands, one quotient bit per clock; start/busy/done handshake.
//  Sits beside the FP multiplier in the ALU datapath; same number handling (denormals flushed, zero result forced +0).
// PARAMETERS
//  QBITS     26   quotient bits generated (integer bit + 23 mantissa + guard + 1 spare); must be 26
//  ROUND_EN  1    1: round-half-up on guard bit (as the multiplier does); 0: truncate
// PORTS
//  clk           in   1   single clock, all state on rising edge
//  rst_n         in   1   reset, asynchronous, active-low
//  start         in   1   request; sampled only in IDLE
//  A             in   32  dividend, IEEE single; latched when start accepted
//  B             in   32  divisor, IEEE single; latched when start accepted
//  busy          out  1   high from cycle after accept until done cycle inclusive
//  done          out  1   one-cycle pulse, Quotient valid
//  Quotient      out  32  result; holds until next done
//  div_by_zero   out  1   valid with done; holds like Quotient
//  overflow      out  1   valid with done; exponent saturated to inf
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, busy=0, done=0, Quotient=0, div_by_zero=0, overflow=0, counter=0.
//  States: IDLE -> DIVIDE (QBITS cycles) -> NORM (1) -> DONE (1) -> IDLE. Special cases: IDLE -> DONE directly.
//  Accept: start=1 in IDLE latches A,B, sign=A[31]^B[31], eA, eB, mA={1,A[22:0]}, mB={1,B[22:0]}, rem=mA (25b).
//  start in any other state is ignored (no queueing). start held high after DONE starts a new op from IDLE.
//  Special cases (priority order, decided in IDLE, exp==0 means zero, denormals flushed):
//   1) A zero and B zero -> 32'h7FC00000, div_by_zero=1
//   2) B zero            -> {sign,8'hFF,23'd0}, div_by_zero=1
//   3) eA==255           -> {sign,8'hFF,23'd0}
//   4) A zero or eB==255 -> 32'h00000000 (+0)
//  DIVIDE, each cycle: if rem>=mB {q=(q<<1)|1; rem=(rem-mB)<<1} else {q=q<<1; rem=rem<<1}. No early termination.
//  NORM: e = eA - eB + 127 (10-bit signed).
//   q[25]=1: man=q[24:2], g=q[1]; q[25]=0: man=q[23:1], g=q[0], e=e-1.
//   ROUND_EN: man=man+g; carry out of 23 bits -> man=0, e=e+1.
//   e>=255 -> {sign,8'hFF,0}, overflow=1. e<=0 -> +0 (underflow flushed, no flag). else {sign,e[7:0],man}.
//  DONE: done=1 for exactly this cycle; Quotient/flags updated on entry to DONE, same cycle as done.
//  Latency: start sampled at edge N -> done high in cycle N+QBITS+2 (=28) normal; N+1 special.
//  busy=1 in DIVIDE, NORM, DONE; 0 in IDLE.
//  Reset mid-operation: abort immediately, outputs to reset values, no done pulse; Quotient not preserved.
//  Flags div_by_zero/overflow cleared on accept of next start.
// TESTING
//  6.0/2.0: A=0x40C00000 B=0x40000000 -> Quotient=0x40400000, done exactly 28 cycles after accept, busy high throughout.
//  1.0/3.0: A=0x3F800000 B=0x40400000 -> 0x3EAAAAAB (guard round-up); ROUND_EN=0 -> 0x3EAAAAAA.
//  1.0/0: B=0x00000000 -> 0x7F800000, div_by_zero=1, done 1 cycle after accept; 0/0 -> 0x7FC00000.
//  Overflow: A=0x7F000000 B=0x3E800000 -> 0x7F800000, overflow=1; underflow A=0x00800000 B=0x7F000000 -> 0x00000000.
//  Sign and ignore: A=0xC0C00000 B=0x40000000 -> 0xC0400000; second start pulsed mid-DIVIDE ignored, one done only.
//  Reset abort: accept 6.0/2.0, drop rst_n at cycle 10 -> busy=0, Quotient=0, no done; new op after release correct.

Source files
------------

// File: rtl/floating_point_divider_seq.sv
// floating_point_divider_seq
//   Sequential IEEE-754 single-precision divider, Quotient = A / B.
//   Restoring shift-subtract on 24-bit significands, one quotient bit per
//   clock. Number handling matches the ALU FP multiplier: denormals are
//   flushed to zero and zero results are always +0.
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : request, only sampled while idle
//   A, B         : dividend / divisor, captured on accept
//   busy         : high in every non-idle state
//   done         : one-cycle pulse, Quotient and flags valid
//   Quotient     : result, holds until the next done
//   div_by_zero  : divisor was zero (held like Quotient)
//   overflow     : exponent saturated to infinity (held like Quotient)
module floating_point_divider_seq #(
  parameter int QBITS    = 26,
  parameter bit ROUND_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] Quotient,
  output logic        div_by_zero,
  output logic        overflow
);

  typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_NORM, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic [7:0]         ea_q, ea_d, eb_q, eb_d;
  logic [23:0]        mb_q, mb_d;
  logic [24:0]        rem_q, rem_d;
  logic [QBITS-1:0]   quo_q, quo_d;
  logic [31:0]        res_q, res_d;
  logic               dz_q, dz_d, ov_q, ov_d;

  // operand classification straight from the inputs (used only on accept)
  logic a_zero, b_zero, a_inf, b_inf, s_in;
  assign a_zero = (A[30:23] == 8'h00);
  assign b_zero = (B[30:23] == 8'h00);
  assign a_inf  = (A[30:23] == 8'hFF);
  assign b_inf  = (B[30:23] == 8'hFF);
  assign s_in   = A[31] ^ B[31];

  // normalisation / rounding of the finished quotient
  logic signed [9:0] e_raw, e_n, e_f;
  logic [22:0]       man, man_f;
  logic              g;
  logic [23:0]       man_r;
  logic [24:0]       rem_sub;

  always_comb begin
    e_raw = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 10'sd127;
    if (quo_q[QBITS-1]) begin
      man = quo_q[QBITS-2:2];
      g   = quo_q[1];
      e_n = e_raw;
    end else begin
      // quotient < 1: shift left one place and borrow from the exponent
      man = quo_q[QBITS-3:1];
      g   = quo_q[0];
      e_n = e_raw - 10'sd1;
    end
    man_r = {1'b0, man} + {23'd0, g & ROUND_EN};
    if (man_r[23]) begin
      man_f = 23'd0;
      e_f   = e_n + 10'sd1;
    end else begin
      man_f = man_r[22:0];
      e_f   = e_n;
    end
  end

  // remainder always stays below 2*mB, so 25 bits never overflow
  assign rem_sub = rem_q - {1'b0, mb_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    ea_d    = ea_q;
    eb_d    = eb_q;
    mb_d    = mb_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    res_d   = res_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sign_d = s_in;
          ea_d   = A[30:23];
          eb_d   = B[30:23];
          mb_d   = {1'b1, B[22:0]};
          rem_d  = {2'b01, A[22:0]};
          quo_d  = '0;
          cnt_d  = 5'd0;
          dz_d   = 1'b0;
          ov_d   = 1'b0;
          state_d = S_DONE;
          if (a_zero && b_zero) begin
            res_d = 32'h7FC0_0000;
            dz_d  = 1'b1;
          end else if (b_zero) begin
            res_d = {s_in, 8'hFF, 23'd0};
            dz_d  = 1'b1;
          end else if (a_inf) begin
            res_d = {s_in, 8'hFF, 23'd0};
          end else if (a_zero || b_inf) begin
            res_d = 32'h0000_0000;
          end else begin
            state_d = S_DIVIDE;
          end
        end
      end
      S_DIVIDE: begin
        if (rem_q >= {1'b0, mb_q}) begin
          quo_d = {quo_q[QBITS-2:0], 1'b1};
          rem_d = {rem_sub[23:0], 1'b0};
        end else begin
          quo_d = {quo_q[QBITS-2:0], 1'b0};
          rem_d = {rem_q[23:0], 1'b0};
        end
        if (cnt_q == 5'(QBITS-1)) begin
          cnt_d   = 5'd0;
          state_d = S_NORM;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_NORM: begin
        state_d = S_DONE;
        if (e_f >= 10'sd255) begin
          res_d = {sign_q, 8'hFF, 23'd0};
          ov_d  = 1'b1;
        end else if (e_f <= 10'sd0) begin
          res_d = 32'h0000_0000;
        end else begin
          res_d = {sign_q, e_f[7:0], man_f};
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      sign_q  <= 1'b0;
      ea_q    <= 8'd0;
      eb_q    <= 8'd0;
      mb_q    <= 24'd0;
      rem_q   <= 25'd0;
      quo_q   <= '0;
      res_q   <= 32'd0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      ea_q    <= ea_d;
      eb_q    <= eb_d;
      mb_q    <= mb_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign Quotient    = res_q;
  assign div_by_zero = dz_q;
  assign overflow    = ov_q;

endmodule

// File: tb/tb_floating_point_divider_seq.sv
// Testbench for floating_point_divider_seq: two instances (rounding on/off)
// share stimulus; a reference model works from plain integer division.
module tb_floating_point_divider_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] A = 32'd0, B = 32'd0;
  logic        busy, done, dz, ov;
  logic [31:0] quo;
  logic        busy0, done0, dz0, ov0;
  logic [31:0] quo0;

  floating_point_divider_seq #(.QBITS(26), .ROUND_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .Quotient(quo), .div_by_zero(dz), .overflow(ov));

  floating_point_divider_seq #(.QBITS(26), .ROUND_EN(1'b0)) dut_t (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .busy(busy0), .done(done0), .Quotient(quo0), .div_by_zero(dz0), .overflow(ov0));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] q;
    logic        dz;
    logic        ov;
    logic        spec;
  } res_t;

  function automatic res_t ref_div(input logic [31:0] a, input logic [31:0] b, input bit rnd);
    res_t   r;
    int     ea, eb, e;
    logic   s;
    longint ma, mb, q, man, g;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    r  = '0;
    r.spec = 1'b1;
    if (ea == 0 && eb == 0) begin
      r.q = 32'h7FC00000; r.dz = 1'b1;
    end else if (eb == 0) begin
      r.q = {s, 8'hFF, 23'd0}; r.dz = 1'b1;
    end else if (ea == 255) begin
      r.q = {s, 8'hFF, 23'd0};
    end else if (ea == 0 || eb == 255) begin
      r.q = 32'd0;
    end else begin
      r.spec = 1'b0;
      ma = longint'({1'b1, a[22:0]});
      mb = longint'({1'b1, b[22:0]});
      q  = (ma << 25) / mb;          // 26-bit fixed point, 25 fraction bits
      e  = ea - eb + 127;
      if (q >= (longint'(1) << 25)) begin
        man = (q >> 2) & 64'h7FFFFF; g = (q >> 1) & 1;
      end else begin
        man = (q >> 1) & 64'h7FFFFF; g = q & 1; e = e - 1;
      end
      if (rnd) man = man + g;
      if (man == 64'h800000) begin man = 0; e = e + 1; end
      if (e >= 255) begin
        r.q = {s, 8'hFF, 23'd0}; r.ov = 1'b1;
      end else if (e <= 0) begin
        r.q = 32'd0;
      end else begin
        r.q = {s, e[7:0], man[22:0]};
      end
    end
    return r;
  endfunction

  res_t r1, r0, pend1, pend0;
  always_comb begin
    r1 = ref_div(A, B, 1'b1);
    r0 = ref_div(A, B, 1'b0);
  end

  // m_ph: 0 idle, 1 computing, 2 result cycle
  int          m_ph = 0, m_left = 0;
  logic [31:0] m_q = 32'd0, m_q0 = 32'd0;
  logic        m_dz = 1'b0, m_ov = 1'b0, m_ov0 = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= 0; m_left <= 0; m_q <= 32'd0; m_q0 <= 32'd0;
      m_dz <= 1'b0; m_ov <= 1'b0; m_ov0 <= 1'b0;
    end else begin
      case (m_ph)
        0: if (start) begin
          if (r1.spec) begin
            m_q <= r1.q; m_q0 <= r0.q; m_dz <= r1.dz; m_ov <= 1'b0; m_ov0 <= 1'b0;
            m_ph <= 2;
          end else begin
            m_dz <= 1'b0; m_ov <= 1'b0; m_ov0 <= 1'b0;
            pend1 <= r1; pend0 <= r0;
            m_left <= 26; m_ph <= 1;
          end
        end
        1: if (m_left == 0) begin
          m_q <= pend1.q; m_q0 <= pend0.q; m_ov <= pend1.ov; m_ov0 <= pend0.ov;
          m_ph <= 2;
        end else begin
          m_left <= m_left - 1;
        end
        default: m_ph <= 0;
      endcase
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      chk1("done", done, m_ph == 2);
      chk1("busy", busy, m_ph != 0);
      chk32("quotient", quo, m_q);
      chk1("div_by_zero", dz, m_dz);
      chk1("overflow", ov, m_ov);
      chk1("done_trunc", done0, m_ph == 2);
      chk1("busy_trunc", busy0, m_ph != 0);
      chk32("quotient_trunc", quo0, m_q0);
      chk1("div_by_zero_trunc", dz0, m_dz);
      chk1("overflow_trunc", ov0, m_ov0);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_idle();
    int guard = 0;
    while (m_ph != 0 && guard < 100) begin @(negedge clk); guard++; end
    if (m_ph != 0) chk1("wait_idle_timeout", 1'b0, 1'b1);
  endtask

  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q1, input logic [31:0] q0,
                        input logic edz, input logic eov, input int lat_exp);
    int lat;
    bit busy_lo;
    wait_idle();
    start = 1'b1; A = a; B = b;
    @(negedge clk);
    start = 1'b0; lat = 1; busy_lo = 1'b0;
    while (!done && lat < 40) begin
      if (!busy) busy_lo = 1'b1;
      @(negedge clk); lat++;
    end
    if (!busy) busy_lo = 1'b1;
    chk32({nm, "_latency"}, 32'(lat), 32'(lat_exp));
    chk1({nm, "_busy_held"}, busy_lo, 1'b0);
    chk32({nm, "_q"}, quo, q1);
    chk32({nm, "_q_trunc"}, quo0, q0);
    chk1({nm, "_dz"}, dz, edz);
    chk1({nm, "_ov"}, ov, eov);
  endtask

  function automatic logic [31:0] rand_fp();
    int r;
    logic [7:0] e;
    r = $urandom_range(0, 9);
    if (r == 0) e = 8'h00;
    else if (r == 1) e = 8'hFF;
    else e = 8'($urandom_range(1, 254));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  initial begin
    res_t t;
    int   n_done;
    // pin the model with hand-computed values
    t = ref_div(32'h40C00000, 32'h40000000, 1'b1); chk32("pin_6_2", t.q, 32'h40400000);
    t = ref_div(32'h3F800000, 32'h40400000, 1'b1); chk32("pin_1_3_rnd", t.q, 32'h3EAAAAAB);
    t = ref_div(32'h3F800000, 32'h40400000, 1'b0); chk32("pin_1_3_trunc", t.q, 32'h3EAAAAAA);
    t = ref_div(32'h7F000000, 32'h3E800000, 1'b1); chk1("pin_ovf", t.ov, 1'b1);

    repeat (3) @(negedge clk);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_done", done, 1'b0);
    chk32("reset_q", quo, 32'd0);
    chk1("reset_dz", dz, 1'b0);
    chk1("reset_ov", ov, 1'b0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    run_op("six_div_two", 32'h40C00000, 32'h40000000, 32'h40400000, 32'h40400000, 1'b0, 1'b0, 28);
    run_op("one_div_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 32'h3EAAAAAA, 1'b0, 1'b0, 28);
    run_op("one_div_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 32'h7F800000, 1'b1, 1'b0, 1);
    run_op("zero_div_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, 32'h7FC00000, 1'b1, 1'b0, 1);
    run_op("overflow", 32'h7F000000, 32'h3E800000, 32'h7F800000, 32'h7F800000, 1'b0, 1'b1, 28);
    run_op("underflow", 32'h00800000, 32'h7F000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 28);
    run_op("inf_div", 32'hFF800000, 32'h40000000, 32'hFF800000, 32'hFF800000, 1'b0, 1'b0, 1);
    run_op("div_by_inf", 32'h40000000, 32'h7F800000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1);

    // negative operand, with a second start pulsed mid-divide
    wait_idle();
    start = 1'b1; A = 32'hC0C00000; B = 32'h40000000;
    @(negedge clk);
    start = 1'b0; n_done = 0;
    for (int i = 1; i <= 40; i++) begin
      if (done) n_done++;
      if (i == 5) begin start = 1'b1; A = 32'h3F800000; B = 32'h40400000; end
      else start = 1'b0;
      @(negedge clk);
    end
    chk32("ignore_done_count", 32'(n_done), 32'd1);
    chk32("neg_six_div_two", quo, 32'hC0400000);

    // reset abort mid-operation
    wait_idle();
    start = 1'b1; A = 32'h40C00000; B = 32'h40000000;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_done", done, 1'b0);
    chk32("abort_q", quo, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("after_abort", 32'h40C00000, 32'h40000000, 32'h40400000, 32'h40400000, 1'b0, 1'b0, 28);

    // randomized traffic; start sometimes held, sometimes pulsed mid-op
    for (int i = 0; i < 5000; i++) begin
      logic [31:0] a, b;
      a = rand_fp();
      b = rand_fp();
      if ($urandom_range(0, 1) == 1 && b[30:23] != 8'h00 && b[30:23] != 8'hFF)
        b[30:23] = a[30:23] + 8'($urandom_range(0, 2)) - 8'd1;
      start = ($urandom_range(0, 2) == 0);
      A = a; B = b;
      @(negedge clk);
    end
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
